// File: rtl/flit_injector.sv
// flit_injector: network-interface transmit side. Turns a packet request plus a
// stream of payload words into header/body/tail flits and writes them into a
// downstream virtual-channel FIFO, backpressured by that FIFO's ready.
//
// Flit layout : {id[FLIT_ID_W-1:0], data[FLIT_DATA_W-1:0]}
// Flit ids    : HEADER_ID=1, BODY_ID=2, TAIL_ID=3 (0 never appears on a valid flit)
// Header data : data[COL_ADDR_W-1:0] = column, next ROW_ADDR_W bits = row, rest 0
module flit_injector #(
   parameter int FLIT_DATA_W = 8,
   parameter int FLIT_ID_W   = 2,
   parameter int COL_ADDR_W  = 2,
   parameter int ROW_ADDR_W  = 2,
   parameter int LEN_W       = 4,
   localparam int FLIT_W     = FLIT_ID_W + FLIT_DATA_W
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   pkt_vld_i,
   output logic                   pkt_rdy_o,
   input  logic [COL_ADDR_W-1:0]  dst_col_i,
   input  logic [ROW_ADDR_W-1:0]  dst_row_i,
   input  logic [LEN_W-1:0]       pkt_len_i,
   input  logic [FLIT_DATA_W-1:0] pld_data_i,
   input  logic                   pld_vld_i,
   output logic                   pld_rdy_o,
   output logic [FLIT_W-1:0]      data_o,
   output logic                   wr_en_o,
   input  logic                   rdy_i,
   output logic                   busy_o
);

   localparam logic [FLIT_ID_W-1:0] HEADER_ID = FLIT_ID_W'(1);
   localparam logic [FLIT_ID_W-1:0] BODY_ID   = FLIT_ID_W'(2);
   localparam logic [FLIT_ID_W-1:0] TAIL_ID   = FLIT_ID_W'(3);
   localparam int                   HDR_PAD_W = FLIT_DATA_W - COL_ADDR_W - ROW_ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_ZTAIL   = 2'd2
   } state_t;

   state_t                 r_state;
   logic                   r_out_vld;
   logic [FLIT_W-1:0]      r_flit;
   logic [LEN_W-1:0]       r_remaining;

   logic                   w_fire;
   logic                   w_load_ok;
   logic                   w_pkt_acc;
   logic                   w_pld_acc;
   logic                   w_last_pld;
   logic [FLIT_DATA_W-1:0] w_hdr_data;

   // The single output register can take a new flit when it is empty or when
   // its current flit leaves this cycle; that keeps the link at 1 flit/cycle.
   assign w_fire     = r_out_vld & rdy_i;
   assign w_load_ok  = ~r_out_vld | w_fire;
   assign pkt_rdy_o  = (r_state == ST_IDLE) & w_load_ok;
   assign pld_rdy_o  = (r_state == ST_PAYLOAD) & w_load_ok;
   assign w_pkt_acc  = pkt_vld_i & pkt_rdy_o;
   assign w_pld_acc  = pld_vld_i & pld_rdy_o;
   assign w_last_pld = (r_remaining == LEN_W'(1));
   assign w_hdr_data = {{HDR_PAD_W{1'b0}}, dst_row_i, dst_col_i};

   assign wr_en_o    = w_fire;
   assign data_o     = r_out_vld ? r_flit : '0;
   assign busy_o     = (r_state != ST_IDLE) | r_out_vld;

   // Packetizer FSM and output flit register. A fire with no new load empties
   // the register; any load in the same cycle overrides that and refills it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_out_vld   <= 1'b0;
         r_flit      <= '0;
         r_remaining <= '0;
      end else begin
         if (w_fire) begin
            r_out_vld <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_pkt_acc) begin
                  r_flit      <= {HEADER_ID, w_hdr_data};
                  r_out_vld   <= 1'b1;
                  r_remaining <= pkt_len_i;
                  r_state     <= (pkt_len_i != '0) ? ST_PAYLOAD : ST_ZTAIL;
               end
            end
            ST_PAYLOAD: begin
               if (w_pld_acc) begin
                  r_flit    <= {(w_last_pld ? TAIL_ID : BODY_ID), pld_data_i};
                  r_out_vld <= 1'b1;
                  if (w_last_pld) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_remaining <= r_remaining - LEN_W'(1);
                  end
               end
            end
            ST_ZTAIL: begin
               // Zero-length packet: close it with a tail carrying no payload.
               if (w_load_ok) begin
                  r_flit    <= {TAIL_ID, {FLIT_DATA_W{1'b0}}};
                  r_out_vld <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flit_injector.sv
// Bench for flit_injector: per-cycle vector table for the directed corner cases,
// then stream tests (back-to-back and randomized) against a flit-list model and
// a small occupancy model of the downstream virtual-channel FIFO.
module tb_flit_injector;

   localparam int FLIT_DATA_W = 8;
   localparam int FLIT_ID_W   = 2;
   localparam int COL_ADDR_W  = 2;
   localparam int ROW_ADDR_W  = 2;
   localparam int LEN_W       = 4;
   localparam int FLIT_W      = 10;
   localparam int VC_DEPTH    = 4;

   logic                   clk;
   logic                   rst_i;
   logic                   pkt_vld_i;
   logic                   pkt_rdy_o;
   logic [COL_ADDR_W-1:0]  dst_col_i;
   logic [ROW_ADDR_W-1:0]  dst_row_i;
   logic [LEN_W-1:0]       pkt_len_i;
   logic [FLIT_DATA_W-1:0] pld_data_i;
   logic                   pld_vld_i;
   logic                   pld_rdy_o;
   logic [FLIT_W-1:0]      data_o;
   logic                   wr_en_o;
   logic                   rdy_i;
   logic                   busy_o;

   flit_injector #(
      .FLIT_DATA_W(FLIT_DATA_W),
      .FLIT_ID_W  (FLIT_ID_W),
      .COL_ADDR_W (COL_ADDR_W),
      .ROW_ADDR_W (ROW_ADDR_W),
      .LEN_W      (LEN_W)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .pkt_vld_i (pkt_vld_i),
      .pkt_rdy_o (pkt_rdy_o),
      .dst_col_i (dst_col_i),
      .dst_row_i (dst_row_i),
      .pkt_len_i (pkt_len_i),
      .pld_data_i(pld_data_i),
      .pld_vld_i (pld_vld_i),
      .pld_rdy_o (pld_rdy_o),
      .data_o    (data_o),
      .wr_en_o   (wr_en_o),
      .rdy_i     (rdy_i),
      .busy_o    (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst;
      logic        pv;
      logic [1:0]  col;
      logic [1:0]  row;
      logic [3:0]  len;
      logic        dv;
      logic [7:0]  dd;
      logic        rdy;
      logic        e_wr;
      logic [9:0]  e_data;
      logic        e_prdy;
      logic        e_drdy;
      logic        e_busy;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t V(logic rst, logic pv, logic [1:0] col, logic [1:0] row,
                              logic [3:0] len, logic dv, logic [7:0] dd, logic rdy,
                              logic e_wr, logic [9:0] e_data, logic e_prdy,
                              logic e_drdy, logic e_busy);
      vec_t v;
      v.rst = rst; v.pv = pv; v.col = col; v.row = row; v.len = len;
      v.dv = dv; v.dd = dd; v.rdy = rdy;
      v.e_wr = e_wr; v.e_data = e_data; v.e_prdy = e_prdy; v.e_drdy = e_drdy; v.e_busy = e_busy;
      return v;
   endfunction

   // ---------------- stream model ----------------
   logic [1:0]  pk_col[$];
   logic [1:0]  pk_row[$];
   logic [3:0]  pk_len[$];
   logic [7:0]  pld_q[$];
   logic [9:0]  exp_q[$];
   int          nwr;

   // Expected link contents: header, then one flit per payload word with the
   // last one tagged tail; a zero-length packet gets a zero-data tail.
   task automatic build_expected();
      int di;
      di = 0;
      exp_q.delete();
      foreach (pk_len[p]) begin
         exp_q.push_back({2'b01, 4'b0000, pk_row[p], pk_col[p]});
         if (pk_len[p] == 0) begin
            exp_q.push_back(10'h300);
         end else begin
            for (int j = 0; j < int'(pk_len[p]); j++) begin
               exp_q.push_back({(j == int'(pk_len[p]) - 1) ? 2'b11 : 2'b10, pld_q[di]});
               di++;
            end
         end
      end
   endtask

   task automatic run_stream(input bit rnd, input bit consec);
      int pi, di, fcnt, cyc, last_wr, npk, nd;
      bit prev_hold, rd;
      logic [9:0] prev_d, e;
      pi = 0; di = 0; fcnt = 0; cyc = 0; last_wr = -1; nwr = 0;
      prev_hold = 0; prev_d = '0;
      npk = pk_len.size();
      nd  = pld_q.size();
      build_expected();
      while (exp_q.size() > 0 && cyc < 20000) begin
         @(negedge clk);
         rdy_i     = rnd ? (fcnt < VC_DEPTH) : 1'b1;
         pkt_vld_i = (pi < npk) && (!rnd || $urandom_range(0, 3) != 0);
         dst_col_i = (pi < npk) ? pk_col[pi] : 2'($urandom);
         dst_row_i = (pi < npk) ? pk_row[pi] : 2'($urandom);
         pkt_len_i = (pi < npk) ? pk_len[pi] : 4'($urandom);
         pld_vld_i = (di < nd) && (!rnd || $urandom_range(0, 3) != 0);
         pld_data_i = (di < nd) ? pld_q[di] : 8'($urandom);
         #2;
         if (prev_hold) check("hold", data_o, prev_d);
         if (wr_en_o) begin
            check("vc_overflow", (fcnt < VC_DEPTH), 1);
            if (exp_q.size() == 0) begin
               check("extra_flit", data_o, 0);
            end else begin
               e = exp_q.pop_front();
               check("flit", data_o, e);
            end
            if (consec && last_wr >= 0) check("gap", cyc - last_wr, 1);
            last_wr = cyc;
            nwr++;
         end
         prev_hold = !wr_en_o && (data_o != '0);
         prev_d    = data_o;
         if (pkt_vld_i && pkt_rdy_o) pi++;
         if (pld_vld_i && pld_rdy_o) di++;
         rd   = (fcnt > 0) && (!rnd || $urandom_range(0, 1) == 0);
         fcnt = fcnt + int'(wr_en_o) - int'(rd);
         cyc++;
      end
      check("all_flits_seen", exp_q.size(), 0);
      check("all_pkts_taken", pi, npk);
      check("all_pld_taken", di, nd);
      @(negedge clk);
      pkt_vld_i = 0; pld_vld_i = 0; rdy_i = 1;
      #2;
      check("idle_after_stream", busy_o, 0);
   endtask

   initial begin
      rst_i = 1; pkt_vld_i = 0; dst_col_i = 0; dst_row_i = 0; pkt_len_i = 0;
      pld_data_i = 0; pld_vld_i = 0; rdy_i = 1;
      repeat (2) @(negedge clk);

      // reset state
      vt.push_back(V(1,0,0,0,0,0,8'h00,1, 0,10'h000,1,0,0));
      // len=3 packet, continuous ready
      vt.push_back(V(0,1,2,1,3,0,8'h00,1, 0,10'h000,1,0,0));
      vt.push_back(V(0,0,0,0,0,1,8'hA1,1, 1,10'h106,0,1,1));
      vt.push_back(V(0,0,0,0,0,1,8'hA2,1, 1,10'h2A1,0,1,1));
      vt.push_back(V(0,0,0,0,0,1,8'hA3,1, 1,10'h2A2,0,1,1));
      vt.push_back(V(0,0,0,0,0,1,8'hEE,1, 1,10'h3A3,1,0,1));
      vt.push_back(V(0,0,0,0,0,0,8'h00,1, 0,10'h000,1,0,0));
      // same packet with a 3-cycle downstream stall on the first body
      vt.push_back(V(0,1,2,1,3,0,8'h00,1, 0,10'h000,1,0,0));
      vt.push_back(V(0,0,0,0,0,1,8'hA1,1, 1,10'h106,0,1,1));
      vt.push_back(V(0,0,0,0,0,1,8'hA2,0, 0,10'h2A1,0,0,1));
      vt.push_back(V(0,0,0,0,0,1,8'hA2,0, 0,10'h2A1,0,0,1));
      vt.push_back(V(0,0,0,0,0,1,8'hA2,0, 0,10'h2A1,0,0,1));
      vt.push_back(V(0,0,0,0,0,1,8'hA2,1, 1,10'h2A1,0,1,1));
      vt.push_back(V(0,0,0,0,0,1,8'hA3,1, 1,10'h2A2,0,1,1));
      vt.push_back(V(0,0,0,0,0,0,8'h00,1, 1,10'h3A3,1,0,1));
      vt.push_back(V(0,0,0,0,0,0,8'h00,1, 0,10'h000,1,0,0));
      // len=1 then len=0 back-to-back; payload offered but never taken for len=0
      vt.push_back(V(0,1,1,3,1,1,8'h55,1, 0,10'h000,1,0,0));
      vt.push_back(V(0,0,0,0,0,1,8'h55,1, 1,10'h10D,0,1,1));
      vt.push_back(V(0,1,0,0,0,1,8'h77,1, 1,10'h355,1,0,1));
      vt.push_back(V(0,0,0,0,0,1,8'h77,1, 1,10'h100,0,0,1));
      vt.push_back(V(0,0,0,0,0,1,8'h77,1, 1,10'h300,1,0,1));
      vt.push_back(V(0,0,0,0,0,0,8'h00,1, 0,10'h000,1,0,0));
      // asynchronous reset in the middle of a body
      vt.push_back(V(0,1,3,2,5,0,8'h00,1, 0,10'h000,1,0,0));
      vt.push_back(V(0,0,0,0,0,1,8'h11,1, 1,10'h10B,0,1,1));
      vt.push_back(V(0,0,0,0,0,1,8'h22,1, 1,10'h211,0,1,1));
      vt.push_back(V(1,0,0,0,0,1,8'h33,1, 0,10'h000,1,0,0));
      vt.push_back(V(0,0,0,0,0,1,8'h33,1, 0,10'h000,1,0,0));

      foreach (vt[i]) begin
         @(negedge clk);
         rst_i = vt[i].rst; pkt_vld_i = vt[i].pv; dst_col_i = vt[i].col;
         dst_row_i = vt[i].row; pkt_len_i = vt[i].len; pld_vld_i = vt[i].dv;
         pld_data_i = vt[i].dd; rdy_i = vt[i].rdy;
         #2;
         check($sformatf("v%0d.wr_en", i), wr_en_o, vt[i].e_wr);
         check($sformatf("v%0d.data", i), data_o, vt[i].e_data);
         check($sformatf("v%0d.pkt_rdy", i), pkt_rdy_o, vt[i].e_prdy);
         check($sformatf("v%0d.pld_rdy", i), pld_rdy_o, vt[i].e_drdy);
         check($sformatf("v%0d.busy", i), busy_o, vt[i].e_busy);
      end

      // two len=3 packets back-to-back: 8 writes in 8 consecutive cycles
      pk_col.delete(); pk_row.delete(); pk_len.delete(); pld_q.delete();
      pk_col.push_back(2'd1); pk_row.push_back(2'd2); pk_len.push_back(4'd3);
      pk_col.push_back(2'd3); pk_row.push_back(2'd0); pk_len.push_back(4'd3);
      pld_q.push_back(8'hB1); pld_q.push_back(8'hB2); pld_q.push_back(8'hB3);
      pld_q.push_back(8'hC1); pld_q.push_back(8'hC2); pld_q.push_back(8'hC3);
      run_stream(1'b0, 1'b1);
      check("b2b_write_count", nwr, 8);

      // 200 random packets with random downstream and payload stalls
      pk_col.delete(); pk_row.delete(); pk_len.delete(); pld_q.delete();
      for (int p = 0; p < 200; p++) begin
         pk_col.push_back(2'($urandom));
         pk_row.push_back(2'($urandom));
         pk_len.push_back(4'($urandom_range(0, 15)));
         for (int j = 0; j < int'(pk_len[p]); j++) pld_q.push_back(8'($urandom));
      end
      run_stream(1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
